// File: rtl/bank_isu_credit_ctrl_pkg.sv
// bank_isu_pkg
//   Shared types, defaults and helpers for the bank issue-queue read-credit
//   manager (bank_isu_credit_ctrl) and its age arbiter (bank_isu_age_arb).
//   No ports; imported with "import bank_isu_pkg::*".
package bank_isu_pkg;

  localparam int CHANNEL_NUM_DEF = 4;
  localparam int PTR_WIDTH_DEF   = 6;
  localparam int CREDIT_MAX      = 8;
  localparam int CH_W_DEF        = (CHANNEL_NUM_DEF > 1) ? $clog2(CHANNEL_NUM_DEF) : 1;
  localparam int CRD_W_DEF       = $clog2(CREDIT_MAX + 1);

  typedef logic [PTR_WIDTH_DEF-1:0] iq_ptr_t;
  typedef logic [CH_W_DEF-1:0]      ch_id_t;
  typedef logic [CRD_W_DEF-1:0]     crd_cnt_t;

  // Base bit index of channel ch inside the flattened per-channel ownership bus.
  function automatic int ch_slice(input int ch, input int depth);
    return ch * depth;
  endfunction

endpackage

// File: rtl/bank_isu_credit_ctrl_if.sv
// bank_isu_credit_ctrl_if
//   Bundles the issue-queue side signals of the read-credit manager.
//   master : issue queue / picker side (drives enqueue, dequeue, release, IQ state)
//   slave  : credit manager side (drives credit_allow_o, credit_num_o, pending_num_o)
//   Signals:
//     iq_enqueue_i, iq_write_ptr_i, op_is_read_i, ch_id_i  enqueue request
//     iq_dequeue_i, iq_deq_ptr_i                           entry removal
//     iq_bottom_ptr_i                                      oldest IQ slot
//     iq_valid_i, iq_req_ch_i                              IQ occupancy / channel ownership
//     credit_release_i                                     one credit back per channel
//     credit_allow_o, credit_num_o, pending_num_o          manager state
interface bank_isu_credit_ctrl_if #(
  parameter int CHANNEL_NUM = 4,
  parameter int PTR_WIDTH   = 6,
  parameter int CREDIT_MAX  = 8
);
  localparam int DEPTH = 1 << PTR_WIDTH;
  localparam int CH_W  = (CHANNEL_NUM > 1) ? $clog2(CHANNEL_NUM) : 1;
  localparam int CRD_W = $clog2(CREDIT_MAX + 1);

  logic                               iq_enqueue_i;
  logic [PTR_WIDTH-1:0]               iq_write_ptr_i;
  logic                               op_is_read_i;
  logic [CH_W-1:0]                    ch_id_i;
  logic                               iq_dequeue_i;
  logic [PTR_WIDTH-1:0]               iq_deq_ptr_i;
  logic [PTR_WIDTH-1:0]               iq_bottom_ptr_i;
  logic [DEPTH-1:0]                   iq_valid_i;
  logic [CHANNEL_NUM*DEPTH-1:0]       iq_req_ch_i;
  logic [CHANNEL_NUM-1:0]             credit_release_i;
  logic [DEPTH-1:0]                   credit_allow_o;
  logic [CHANNEL_NUM*CRD_W-1:0]       credit_num_o;
  logic [CHANNEL_NUM*(PTR_WIDTH+1)-1:0] pending_num_o;

  modport master (
    output iq_enqueue_i, iq_write_ptr_i, op_is_read_i, ch_id_i,
           iq_dequeue_i, iq_deq_ptr_i, iq_bottom_ptr_i,
           iq_valid_i, iq_req_ch_i, credit_release_i,
    input  credit_allow_o, credit_num_o, pending_num_o
  );

  modport slave (
    input  iq_enqueue_i, iq_write_ptr_i, op_is_read_i, ch_id_i,
           iq_dequeue_i, iq_deq_ptr_i, iq_bottom_ptr_i,
           iq_valid_i, iq_req_ch_i, credit_release_i,
    output credit_allow_o, credit_num_o, pending_num_o
  );

endinterface

// File: rtl/bank_isu_credit_ctrl_age_arb.sv
// bank_isu_age_arb
//   Age arbiter: picks the first set bit of valid_i scanning upward from
//   bottom_ptr_i with wrap-around, i.e. the candidate closest to the oldest
//   IQ slot. DEPTH must equal 1<<PTR_WIDTH so pointer arithmetic wraps.
//   Ports:
//     valid_i      in  DEPTH      candidate vector
//     bottom_ptr_i in  PTR_WIDTH  scan start (oldest slot)
//     sel_ptr_o    out PTR_WIDTH  selected slot (0 when none)
//     sel_vld_o    out 1          a candidate was found
module bank_isu_age_arb
  import bank_isu_pkg::*;
#(
  parameter int DEPTH     = 64,
  parameter int PTR_WIDTH = 6
) (
  input  logic [DEPTH-1:0]     valid_i,
  input  logic [PTR_WIDTH-1:0] bottom_ptr_i,
  output logic [PTR_WIDTH-1:0] sel_ptr_o,
  output logic                 sel_vld_o
);

  logic [PTR_WIDTH-1:0] idx;

  // Scan from the youngest offset down to offset 0 so the last hit,
  // which is the one kept, is the oldest candidate.
  always_comb begin
    sel_ptr_o = '0;
    sel_vld_o = 1'b0;
    idx       = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      idx = bottom_ptr_i + PTR_WIDTH'(i);
      if (valid_i[idx]) begin
        sel_ptr_o = idx;
        sel_vld_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bank_isu_credit_ctrl.sv
// bank_isu_credit_ctrl
//   Per-channel read-credit manager for the bank issue queue. Reads enqueued
//   on a channel take a credit at once when the channel has credit and no
//   older pending read; otherwise they are counted as pending and later
//   granted oldest-first (relative to iq_bottom_ptr_i) as credits return.
//   Writes are always allowed. All outputs come straight from flops.
//   Ports:
//     clk    in   clock
//     rst    in   asynchronous active-high reset
//     bus    slave modport of bank_isu_credit_ctrl_if (IQ handshake + state)
//     err_o  out  sticky error flag, present only with BANK_ISU_CREDIT_ERR_EN
//   Optional feature macro: BANK_ISU_CREDIT_ERR_EN
//     err_o is set on a saturating release, a grant attempt with no
//     candidate, or a dequeue of a valid entry that holds no credit.
module bank_isu_credit_ctrl #(
  parameter int CHANNEL_NUM = bank_isu_pkg::CHANNEL_NUM_DEF,
  parameter int PTR_WIDTH   = bank_isu_pkg::PTR_WIDTH_DEF,
  parameter int CREDIT_MAX  = bank_isu_pkg::CREDIT_MAX
) (
  input  logic                  clk,
  input  logic                  rst,
  bank_isu_credit_ctrl_if.slave bus
`ifdef BANK_ISU_CREDIT_ERR_EN
  ,
  output logic                  err_o
`endif
);
  import bank_isu_pkg::*;

  localparam int DEPTH = 1 << PTR_WIDTH;
  localparam int CH_W  = (CHANNEL_NUM > 1) ? $clog2(CHANNEL_NUM) : 1;
  localparam int CRD_W = $clog2(CREDIT_MAX + 1);
  localparam int PN_W  = PTR_WIDTH + 1;

  localparam logic [CRD_W-1:0] CRD_ONE  = CRD_W'(1);
  localparam logic [CRD_W-1:0] CRD_FULL = CRD_W'(CREDIT_MAX);
  localparam logic [PN_W-1:0]  PN_ONE   = PN_W'(1);

  logic [DEPTH-1:0]     allow_q, allow_d;
  logic [CRD_W-1:0]     crd_q  [CHANNEL_NUM];
  logic [CRD_W-1:0]     crd_d  [CHANNEL_NUM];
  logic [PN_W-1:0]      pend_q [CHANNEL_NUM];
  logic [PN_W-1:0]      pend_d [CHANNEL_NUM];

  logic [CHANNEL_NUM-1:0] has_crd, has_pend;
  logic [CHANNEL_NUM-1:0] enq_rd, enq_alloc, enq_pend;
  logic [CHANNEL_NUM-1:0] grant_req, grant, alloc;
  logic [CHANNEL_NUM-1:0] sel_vld;
  logic [PTR_WIDTH-1:0]   sel_ptr [CHANNEL_NUM];
  logic [DEPTH-1:0]       cand    [CHANNEL_NUM];

  // One age arbiter per channel over that channel's valid, not-yet-allowed entries.
  for (genvar g = 0; g < CHANNEL_NUM; g++) begin : g_ch
    localparam int BASE = ch_slice(g, DEPTH);

    assign cand[g] = bus.iq_req_ch_i[BASE +: DEPTH] & bus.iq_valid_i & ~allow_q;

    bank_isu_age_arb #(
      .DEPTH     (DEPTH),
      .PTR_WIDTH (PTR_WIDTH)
    ) u_arb (
      .valid_i      (cand[g]),
      .bottom_ptr_i (bus.iq_bottom_ptr_i),
      .sel_ptr_o    (sel_ptr[g]),
      .sel_vld_o    (sel_vld[g])
    );

    assign bus.credit_num_o[g*CRD_W +: CRD_W] = crd_q[g];
    assign bus.pending_num_o[g*PN_W +: PN_W]  = pend_q[g];
  end

  assign bus.credit_allow_o = allow_q;

  // Enqueue allocation and grants are mutually exclusive per channel: an
  // enqueue only takes a credit when nothing is pending, a grant only fires
  // when something is pending. A read arriving while a grant fires is parked.
  always_comb begin
    has_crd   = '0;
    has_pend  = '0;
    enq_rd    = '0;
    enq_alloc = '0;
    enq_pend  = '0;
    grant_req = '0;
    grant     = '0;
    alloc     = '0;
    for (int c = 0; c < CHANNEL_NUM; c++) begin
      has_crd[c]   = crd_q[c] != '0;
      has_pend[c]  = pend_q[c] != '0;
      enq_rd[c]    = bus.iq_enqueue_i && bus.op_is_read_i && (bus.ch_id_i == CH_W'(c));
      enq_alloc[c] = enq_rd[c] && !has_pend[c] && has_crd[c];
      enq_pend[c]  = enq_rd[c] && !enq_alloc[c];
      grant_req[c] = has_crd[c] && has_pend[c];
      grant[c]     = grant_req[c] && sel_vld[c];
      alloc[c]     = enq_alloc[c] || grant[c];
    end
  end

  // Credit and pending counters. Alloc and release in the same cycle cancel;
  // a release with the channel already full saturates.
  always_comb begin
    for (int c = 0; c < CHANNEL_NUM; c++) begin
      crd_d[c] = crd_q[c];
      if (alloc[c] && !bus.credit_release_i[c]) begin
        crd_d[c] = crd_q[c] - CRD_ONE;
      end else if (!alloc[c] && bus.credit_release_i[c] && (crd_q[c] != CRD_FULL)) begin
        crd_d[c] = crd_q[c] + CRD_ONE;
      end

      pend_d[c] = pend_q[c];
      if (enq_pend[c] && !grant[c]) begin
        pend_d[c] = pend_q[c] + PN_ONE;
      end else if (!enq_pend[c] && grant[c]) begin
        pend_d[c] = pend_q[c] - PN_ONE;
      end
    end
  end

  // Allow vector: later assignments win, so dequeue overrides grants, which
  // override the enqueue write.
  always_comb begin
    allow_d = allow_q;
    if (bus.iq_enqueue_i) begin
      allow_d[bus.iq_write_ptr_i] = !bus.op_is_read_i || (|enq_alloc);
    end
    for (int c = 0; c < CHANNEL_NUM; c++) begin
      if (grant[c]) begin
        allow_d[sel_ptr[c]] = 1'b1;
      end
    end
    if (bus.iq_dequeue_i) begin
      allow_d[bus.iq_deq_ptr_i] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      allow_q <= '0;
      for (int c = 0; c < CHANNEL_NUM; c++) begin
        crd_q[c]  <= CRD_FULL;
        pend_q[c] <= '0;
      end
    end else begin
      allow_q <= allow_d;
      for (int c = 0; c < CHANNEL_NUM; c++) begin
        crd_q[c]  <= crd_d[c];
        pend_q[c] <= pend_d[c];
      end
    end
  end

`ifdef BANK_ISU_CREDIT_ERR_EN
  logic                   err_set;
  logic [CHANNEL_NUM-1:0] sat_rel;

  // Flags protocol anomalies that are otherwise absorbed silently.
  always_comb begin
    sat_rel = '0;
    for (int c = 0; c < CHANNEL_NUM; c++) begin
      sat_rel[c] = bus.credit_release_i[c] && !alloc[c] && (crd_q[c] == CRD_FULL);
    end
    err_set = (|sat_rel) || (|(grant_req & ~sel_vld)) ||
              (bus.iq_dequeue_i && bus.iq_valid_i[bus.iq_deq_ptr_i] &&
               !allow_q[bus.iq_deq_ptr_i]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_o <= 1'b0;
    end else if (err_set) begin
      err_o <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_bank_isu_credit_ctrl.sv
// tb_bank_isu_credit_ctrl
//   Scoreboard bench for bank_isu_credit_ctrl. The bench plays the issue
//   queue: it tracks slot occupancy, op type and channel, and keeps a
//   behavioural model of credits, pending counts and allow bits. Each
//   stimulus cycle pushes the expected post-edge state; a monitor pops and
//   compares it on the following falling edge.
module tb_bank_isu_credit_ctrl;
  localparam int CH    = 4;
  localparam int PW    = 6;
  localparam int DEPTH = 64;
  localparam int CMAX  = 8;
  localparam int CRD_W = 4;
  localparam int PN_W  = 7;

  typedef struct {
    logic [DEPTH-1:0]     allow;
    logic [CH*CRD_W-1:0]  crd;
    logic [CH*PN_W-1:0]   pend;
    string                tag;
  } exp_t;

  logic clk;
  logic rst;
`ifdef BANK_ISU_CREDIT_ERR_EN
  logic err_o;
`endif

  bank_isu_credit_ctrl_if #(.CHANNEL_NUM(CH), .PTR_WIDTH(PW), .CREDIT_MAX(CMAX)) bus ();

  bank_isu_credit_ctrl #(.CHANNEL_NUM(CH), .PTR_WIDTH(PW), .CREDIT_MAX(CMAX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef BANK_ISU_CREDIT_ERR_EN
    ,
    .err_o (err_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  int  m_crd   [CH];
  int  m_pend  [CH];
  bit  m_allow [DEPTH];
  bit  q_valid [DEPTH];
  bit  q_read  [DEPTH];
  int  q_ch    [DEPTH];

  exp_t sb[$];
  int   err_count;
  int   check_count;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    check_count++;
    if (act !== exp_v) begin
      err_count++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp_v);
    end
  endtask

  task automatic model_clear();
    for (int c = 0; c < CH; c++) begin
      m_crd[c]  = CMAX;
      m_pend[c] = 0;
    end
    for (int i = 0; i < DEPTH; i++) begin
      m_allow[i] = 1'b0;
      q_valid[i] = 1'b0;
      q_read[i]  = 1'b0;
      q_ch[i]    = 0;
    end
  endtask

  task automatic drive_idle();
    bus.iq_enqueue_i     = 1'b0;
    bus.iq_write_ptr_i   = '0;
    bus.op_is_read_i     = 1'b0;
    bus.ch_id_i          = '0;
    bus.iq_dequeue_i     = 1'b0;
    bus.iq_deq_ptr_i     = '0;
    bus.iq_bottom_ptr_i  = '0;
    bus.iq_valid_i       = '0;
    bus.iq_req_ch_i      = '0;
    bus.credit_release_i = '0;
  endtask

  // One clock of stimulus: drive inputs, advance the model, push the
  // state expected after the next rising edge.
  task automatic applyStimulus(input bit enq, input int wptr, input bit rd, input int ch,
                               input bit deq, input int dptr, input logic [CH-1:0] rel,
                               input int bottom, input string tag);
    logic [DEPTH-1:0]    v;
    logic [CH*DEPTH-1:0] rq;
    int   pre_crd [CH];
    int   pre_pend[CH];
    int   used    [CH];
    int   best, best_age, age;
    exp_t ex;

    @(negedge clk);
    #1;
    v  = '0;
    rq = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (q_valid[i]) begin
        v[i] = 1'b1;
        if (q_read[i]) rq[q_ch[i]*DEPTH + i] = 1'b1;
      end
    end
    bus.iq_enqueue_i     = enq;
    bus.iq_write_ptr_i   = PW'(wptr);
    bus.op_is_read_i     = rd;
    bus.ch_id_i          = 2'(ch);
    bus.iq_dequeue_i     = deq;
    bus.iq_deq_ptr_i     = PW'(dptr);
    bus.iq_bottom_ptr_i  = PW'(bottom);
    bus.iq_valid_i       = v;
    bus.iq_req_ch_i      = rq;
    bus.credit_release_i = rel;

    for (int c = 0; c < CH; c++) begin
      pre_crd[c]  = m_crd[c];
      pre_pend[c] = m_pend[c];
      used[c]     = 0;
    end

    if (enq) begin
      if (!rd) begin
        m_allow[wptr] = 1'b1;
      end else if (pre_pend[ch] == 0 && pre_crd[ch] > 0) begin
        m_allow[wptr] = 1'b1;
        used[ch]++;
      end else begin
        m_allow[wptr] = 1'b0;
        m_pend[ch]++;
      end
    end

    // Oldest waiting read of the channel, by distance from the bottom pointer.
    for (int c = 0; c < CH; c++) begin
      if (pre_crd[c] > 0 && pre_pend[c] > 0) begin
        best     = -1;
        best_age = DEPTH;
        for (int i = 0; i < DEPTH; i++) begin
          if (q_valid[i] && q_read[i] && q_ch[i] == c && !m_allow[i]) begin
            age = (i - bottom + DEPTH) % DEPTH;
            if (age < best_age) begin
              best_age = age;
              best     = i;
            end
          end
        end
        if (best >= 0) begin
          m_allow[best] = 1'b1;
          used[c]++;
          m_pend[c]--;
        end
      end
    end

    if (deq) m_allow[dptr] = 1'b0;

    for (int c = 0; c < CH; c++) begin
      m_crd[c] = pre_crd[c] - used[c] + int'(rel[c]);
      if (m_crd[c] > CMAX) m_crd[c] = CMAX;
    end

    if (enq) begin
      q_valid[wptr] = 1'b1;
      q_read[wptr]  = rd;
      q_ch[wptr]    = ch;
    end
    if (deq) q_valid[dptr] = 1'b0;

    for (int i = 0; i < DEPTH; i++) ex.allow[i] = m_allow[i];
    for (int c = 0; c < CH; c++) begin
      ex.crd[c*CRD_W +: CRD_W] = CRD_W'(m_crd[c]);
      ex.pend[c*PN_W +: PN_W]  = PN_W'(m_pend[c]);
    end
    ex.tag = tag;
    sb.push_back(ex);
  endtask

  task automatic idle(input int n, input string tag);
    for (int k = 0; k < n; k++) applyStimulus(0, 0, 0, 0, 0, 0, '0, 0, tag);
  endtask

  // Wait (bounded) for the monitor to consume every pending expectation.
  task automatic drain();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      #1;
      if (sb.size() == 0) break;
    end
    check_count++;
    if (sb.size() != 0) begin
      err_count++;
      $display("[TB] FAIL drain: got %0d queued expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive_idle();
    model_clear();
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    checkOutput("reset.allow", 64'(bus.credit_allow_o), 64'h0);
    checkOutput("reset.crd", 64'(bus.credit_num_o), 64'h8888);
    checkOutput("reset.pend", 64'(bus.pending_num_o), 64'h0);
  endtask

  // Monitor: every falling edge reflects the previous rising edge.
  initial begin
    exp_t ex;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        ex = sb.pop_front();
        checkOutput({ex.tag, ".allow"}, 64'(bus.credit_allow_o), 64'(ex.allow));
        checkOutput({ex.tag, ".crd"}, 64'(bus.credit_num_o), 64'(ex.crd));
        checkOutput({ex.tag, ".pend"}, 64'(bus.pending_num_o), 64'(ex.pend));
      end
    end
  end

  initial begin
    int  wptr, dptr, start;
    bit  enq, deq, rd, found;
    int  ch;
    logic [CH-1:0] rel;

    err_count   = 0;
    check_count = 0;
    rst = 1'b1;
    drive_idle();
    model_clear();

    // Reset values, then nine ch1 reads into slots 0..8
    do_reset();
    for (int s = 0; s < 9; s++) applyStimulus(1, s, 1, 1, 0, 0, '0, 0, "t2_enq");
    idle(1, "t2_hold");
    // One ch1 release lets slot 8 take the credit
    applyStimulus(0, 0, 0, 0, 0, 0, 4'b0010, 0, "t3_rel");
    idle(3, "t3_grant");
    drain();

    // Wrap-around age order: ch2 pending at slots 2 and 60, bottom at 58
    do_reset();
    for (int s = 10; s < 18; s++) applyStimulus(1, s, 1, 2, 0, 0, '0, 58, "t4_fill");
    applyStimulus(1, 2, 1, 2, 0, 0, '0, 58, "t4_pend2");
    applyStimulus(1, 60, 1, 2, 0, 0, '0, 58, "t4_pend60");
    applyStimulus(0, 0, 0, 0, 0, 0, 4'b0100, 58, "t4_rel1");
    idle(2, "t4_g1");
    applyStimulus(0, 0, 0, 0, 0, 0, 4'b0100, 58, "t4_rel2");
    idle(2, "t4_g2");
    drain();

    // ch0 at 3 credits: enqueue+release cancel, then saturation at 8
    do_reset();
    for (int s = 0; s < 5; s++) applyStimulus(1, s, 1, 0, 0, 0, '0, 0, "t5_fill");
    applyStimulus(1, 5, 1, 0, 0, 0, 4'b0001, 0, "t5_cancel");
    for (int k = 0; k < 7; k++) applyStimulus(0, 0, 0, 0, 0, 0, 4'b0001, 0, "t5_sat");
    drain();

    // Enqueue and dequeue of the same slot: dequeue wins
    do_reset();
    applyStimulus(1, 5, 0, 0, 1, 5, '0, 0, "t6_same");
    idle(1, "t6_hold");
    drain();

    // Randomized traffic: the bench acts as the IQ, issuing only allowed entries
    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      enq  = ($urandom_range(0, 99) < 50);
      wptr = 0;
      if (enq) begin
        found = 1'b0;
        start = $urandom_range(0, DEPTH - 1);
        for (int k = 0; k < DEPTH; k++) begin
          if (!found && !q_valid[(start + k) % DEPTH]) begin
            found = 1'b1;
            wptr  = (start + k) % DEPTH;
          end
        end
        enq = found;
      end
      rd = ($urandom_range(0, 3) != 0);
      ch = $urandom_range(0, CH - 1);

      deq  = ($urandom_range(0, 99) < 40);
      dptr = 0;
      if (deq) begin
        found = 1'b0;
        start = $urandom_range(0, DEPTH - 1);
        for (int k = 0; k < DEPTH; k++) begin
          if (!found && q_valid[(start + k) % DEPTH] && m_allow[(start + k) % DEPTH]) begin
            found = 1'b1;
            dptr  = (start + k) % DEPTH;
          end
        end
        deq = found;
      end

      for (int c = 0; c < CH; c++) rel[c] = ($urandom_range(0, 99) < 30);
      applyStimulus(enq, wptr, rd, ch, deq, dptr, rel, $urandom_range(0, DEPTH - 1), "rand");
    end
    drain();

    $display("Result: errors=%0d of %0d checks", err_count, check_count);
    $finish;
  end

endmodule
